// File: rtl/button_pkg.sv
// Shared types and helpers for the front-panel button event arbiter.
package button_pkg;

  typedef enum logic {IDLE, OFFER} arb_state_t;

  localparam int MIN_BUTTONS = 2;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: the level only follows the input after STABLE_TICKS
// consecutive sample ticks of disagreement.
module debounce_channel #(
  parameter int STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic level
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (din == level) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CW'(STABLE_TICKS - 1)) begin
        level <= din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Synchronises and debounces the front-panel buttons, latches presses as
// pending events and offers them one at a time with round-robin priority.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int N_BUTTONS    = 4,
  parameter int TICK_CYCLES  = 50000,
  parameter int STABLE_TICKS = 20,
  localparam int ID_W        = id_width(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] button_pressed,
  output logic                 event_valid,
  output logic [ID_W-1:0]      event_id,
  input  logic                 event_ready,
  output logic                 event_lost
);

  localparam int PS_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [N_BUTTONS-1:0] sync1, sync2, pressed_d, pending, rise, clr;
  logic [PS_W-1:0]      ps_cnt;
  logic                 tick;
  arb_state_t           state;
  logic [ID_W-1:0]      last_grant, pick_id;
  logic                 pick_found;
  int                   idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  assign tick = (ps_cnt == PS_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_db
    debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .din   (sync2[gi]),
      .level (button_pressed[gi])
    );
  end

  assign rise = button_pressed & ~pressed_d;

  always_comb begin
    clr = '0;
    if (state == OFFER && event_ready) clr[event_id] = 1'b1;
  end

  // A press landing on a still-pending, not-being-accepted bit is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_d  <= '0;
      pending    <= '0;
      event_lost <= 1'b0;
    end else begin
      pressed_d  <= button_pressed;
      pending    <= (pending & ~clr) | rise;
      event_lost <= |(rise & pending & ~clr);
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 1; k <= N_BUTTONS; k++) begin
      idx = (int'(last_grant) + k) % N_BUTTONS;
      if (!pick_found && pending[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      event_valid <= 1'b0;
      event_id    <= '0;
      last_grant  <= ID_W'(N_BUTTONS - 1);
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          event_id    <= pick_id;
          event_valid <= 1'b1;
          state       <= OFFER;
        end
        OFFER: if (event_ready) begin
          event_valid <= 1'b0;
          last_grant  <= event_id;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: stimulus queues expected event ids, a negedge monitor
// pops and compares them on every accepted handshake.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] button = '0;
  logic [3:0] button_pressed;
  logic       event_valid;
  logic [1:0] event_id;
  logic       event_ready = 1'b0;
  logic       event_lost;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int accepted = 0;
  int lost_seen = 0;
  int exp_q[$];
  int acc_cyc[$];

  button_event_arbiter #(.N_BUTTONS(4), .TICK_CYCLES(10), .STABLE_TICKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .button_pressed(button_pressed),
    .event_valid(event_valid), .event_id(event_id), .event_ready(event_ready),
    .event_lost(event_lost)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every accepted offer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && event_valid) begin
      valid_cycles++;
      if (event_ready) begin
        accepted++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event got=%0d expected=none", event_id);
        end else begin
          check("event_id", int'(event_id), exp_q.pop_front());
        end
      end
    end
    if (rst_n && event_lost) lost_seen++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v0, a0, l0;
    logic seen;

    // 1: reset state with random buttons
    button = 4'($urandom);
    wait_cycles(5);
    check("rst_pressed", int'(button_pressed), 0);
    check("rst_valid", int'(event_valid), 0);
    check("rst_id", int'(event_id), 0);
    check("rst_lost", int'(event_lost), 0);
    button = '0;
    rst_n = 1'b1;
    v0 = valid_cycles;
    wait_cycles(100);
    check("idle_after_rst", valid_cycles - v0, 0);

    // 2: 25-cycle glitch on button 0 is rejected
    event_ready = 1'b1;
    v0 = valid_cycles;
    seen = 1'b0;
    button[0] = 1'b1;
    for (int i = 0; i < 85; i++) begin
      if (i == 25) button[0] = 1'b0;
      @(negedge clk);
      seen |= button_pressed[0];
    end
    check("glitch_pressed", int'(seen), 0);
    check("glitch_valid", valid_cycles - v0, 0);

    // 3: clean press of button 2
    v0 = valid_cycles;
    exp_q.push_back(2);
    button[2] = 1'b1;
    n = 0;
    while (n <= 60) begin
      @(negedge clk);
      n++;
      if (button_pressed[2]) break;
    end
    check("press_lat_ok", int'(n >= 33 && n <= 42), 1);
    wait_cycles(100 - n);
    button[2] = 1'b0;
    wait_cycles(60);
    check("press_valid_cycles", valid_cycles - v0, 1);
    check("press_q_empty", exp_q.size(), 0);

    // 4: round-robin from a fresh reset (button 0 first)
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    acc_cyc.delete();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    button = 4'b1011;
    wait_cycles(60);
    check("rr_count", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check("rr_gap01", acc_cyc[1] - acc_cyc[0], 2);
      check("rr_gap13", acc_cyc[2] - acc_cyc[1], 2);
    end
    button = '0;
    wait_cycles(60);
    exp_q.push_back(1);
    button = 4'b0010;
    wait_cycles(60);
    button = '0;
    wait_cycles(60);
    exp_q.push_back(3); exp_q.push_back(0);
    button = 4'b1001;
    wait_cycles(60);
    button = '0;
    wait_cycles(60);
    check("rr_q_empty", exp_q.size(), 0);

    // 5: backpressure, then a second press of button 1 is lost
    event_ready = 1'b0;
    a0 = accepted;
    l0 = lost_seen;
    exp_q.push_back(1);
    button[1] = 1'b1;
    wait_cycles(50);
    check("bp_valid", int'(event_valid), 1);
    check("bp_id", int'(event_id), 1);
    button[1] = 1'b0;
    wait_cycles(50);
    button[1] = 1'b1;
    wait_cycles(50);
    check("bp_lost_once", lost_seen - l0, 1);
    check("bp_valid_held", int'(event_valid), 1);
    check("bp_id_held", int'(event_id), 1);
    event_ready = 1'b1;
    wait_cycles(20);
    check("bp_accepts", accepted - a0, 1);
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_no_reoffer", int'(event_valid), 0);
    button[1] = 1'b0;
    wait_cycles(60);

    // 6: asynchronous reset while offering
    event_ready = 1'b0;
    button[2] = 1'b1;
    wait_cycles(50);
    check("mid_valid", int'(event_valid), 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    button = '0;
    #1 check("async_valid_drop", int'(event_valid), 0);
    wait_cycles(3);
    rst_n = 1'b1;
    event_ready = 1'b1;
    v0 = valid_cycles;
    wait_cycles(100);
    check("post_rst_no_offer", valid_cycles - v0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
